// File: rtl/vga_pix_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_pix_pkg                                                        |
// | Shared types, colour constants and latency helper for pixel fetch. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package vga_pix_pkg;

   typedef enum logic [0:0] {
      S_WAIT   = 1'b0,
      S_ACTIVE = 1'b1
   } fetch_state_t;

   // Per-pixel qualifiers carried alongside the memory read
   typedef struct packed {
      logic       hsync;
      logic       vsync;
      logic       blank;
      logic       sync;
      logic       enable;
      logic       in_range;
      logic       active;
      logic       tmode;
      logic [2:0] bar;
   } pix_ctl_t;

   localparam logic [23:0] RGB_BLACK = 24'h000000;

   localparam logic [23:0] BAR_COLOR [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   function automatic int latency(input int rd_lat);
      return rd_lat + 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_fetch_sync_delay.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_sync_delay                                                     |
// | Resettable fixed-depth shift register for timing/qualifier bits.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module vga_sync_delay #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= RESET_VAL;
         end
      end else begin
         r_stage[0] <= i_din;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_dout = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_pixel_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_pixel_fetch                                                    |
// | Frame-memory fetch, gray-to-RGB expansion and sync alignment.      |
// | Optional test bars enabled by macro VGA_TEST_PATTERN_EN.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module vga_pixel_fetch
   import vga_pix_pkg::*;
#(
`ifdef VGA_TEST_PATTERN_EN
   parameter int          H_ACTIVE  = 640,
`endif
   parameter int          RD_LAT    = 2,
   parameter int          MEM_DEPTH = 307200,
   parameter logic [23:0] BG_COLOR  = 24'h000040
) (
   input  logic        vgaclk,
   input  logic        reset,
`ifdef VGA_TEST_PATTERN_EN
   input  logic        test_mode,
`endif
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        blank_in,
   input  logic        sync_in,
   input  logic [18:0] DataAdr_in,
   input  logic        enable_pixel_in,
   output logic [18:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_rdata,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        blank_out,
   output logic        sync_out,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        frame_active
);

   localparam int          c_lat   = latency(RD_LAT);
   localparam logic [19:0] c_depth = 20'(MEM_DEPTH);
   localparam pix_ctl_t    c_ctl_idle = '{hsync: 1'b1, vsync: 1'b1, default: '0};

   fetch_state_t r_state;
   fetch_state_t w_state_next;
   logic         r_vsync_prev;
   logic         w_in_range;
   logic         w_rd;
   logic         w_tmode;
   logic [2:0]   w_bar;
   pix_ctl_t     w_ctl_in;
   pix_ctl_t     w_ctl_d;
   logic [23:0]  w_rgb;

`ifdef VGA_TEST_PATTERN_EN
   localparam int c_bar_w = H_ACTIVE / 8;

   logic [10:0] r_col;
   logic [10:0] w_bar_full;

   always_ff @(posedge vgaclk) begin
      if (reset || !blank_in) begin
         r_col <= '0;
      end else begin
         r_col <= r_col + 11'd1;
      end
   end

   assign w_bar_full = r_col / 11'(c_bar_w);
   assign w_bar      = (w_bar_full > 11'd7) ? 3'd7 : w_bar_full[2:0];
   assign w_tmode    = test_mode;
`else
   assign w_bar   = 3'd0;
   assign w_tmode = 1'b0;
`endif

   // Zero-extended compare so a MEM_DEPTH of 2^19 still works
   assign w_in_range = ({1'b0, DataAdr_in} < c_depth);
   assign w_rd       = enable_pixel_in & blank_in & w_in_range & ~w_tmode;

   always_ff @(posedge vgaclk) begin
      if (reset) begin
         mem_rd   <= 1'b0;
         mem_addr <= '0;
      end else begin
         mem_rd <= w_rd;
         if (w_rd) begin
            mem_addr <= DataAdr_in;
         end
      end
   end

   always_ff @(posedge vgaclk) begin
      if (reset) begin
         r_state      <= S_WAIT;
         r_vsync_prev <= 1'b1;
      end else begin
         r_state      <= w_state_next;
         r_vsync_prev <= vsync_in;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_WAIT:   if (!vsync_in && r_vsync_prev) w_state_next = S_ACTIVE;
         S_ACTIVE: w_state_next = S_ACTIVE;
         default:  w_state_next = S_WAIT;
      endcase
   end

   assign frame_active = (r_state == S_ACTIVE);

   always_comb begin
      w_ctl_in          = c_ctl_idle;
      w_ctl_in.hsync    = hsync_in;
      w_ctl_in.vsync    = vsync_in;
      w_ctl_in.blank    = blank_in;
      w_ctl_in.sync     = sync_in;
      w_ctl_in.enable   = enable_pixel_in;
      w_ctl_in.in_range = w_in_range;
      w_ctl_in.active   = frame_active;
      w_ctl_in.tmode    = w_tmode;
      w_ctl_in.bar      = w_bar;
   end

   // The output register below supplies the last of the c_lat stages
   vga_sync_delay #(
      .WIDTH     ($bits(pix_ctl_t)),
      .DEPTH     (c_lat - 1),
      .RESET_VAL (c_ctl_idle)
   ) u_ctl_delay (
      .clk    (vgaclk),
      .rst    (reset),
      .i_din  (w_ctl_in),
      .o_dout (w_ctl_d)
   );

   always_comb begin
      w_rgb = RGB_BLACK;
      if (w_ctl_d.active && w_ctl_d.blank) begin
         if (w_ctl_d.tmode) begin
            w_rgb = BAR_COLOR[w_ctl_d.bar];
         end else if (w_ctl_d.enable && w_ctl_d.in_range) begin
            w_rgb = {3{mem_rdata}};
         end else begin
            w_rgb = BG_COLOR;
         end
      end
   end

   always_ff @(posedge vgaclk) begin
      if (reset) begin
         hsync_out <= 1'b1;
         vsync_out <= 1'b1;
         blank_out <= 1'b0;
         sync_out  <= 1'b0;
         {red, green, blue} <= RGB_BLACK;
      end else begin
         hsync_out <= w_ctl_d.hsync;
         vsync_out <= w_ctl_d.vsync;
         blank_out <= w_ctl_d.blank;
         sync_out  <= w_ctl_d.sync;
         {red, green, blue} <= w_rgb;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vga_pixel_fetch                                                 |
// | Randomised bench with a cycle-history reference model.             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_vga_pixel_fetch;

   localparam int          RD_LAT    = 2;
   localparam int          MEM_DEPTH = 307200;
   localparam int          H_ACTIVE  = 640;
   localparam logic [23:0] BG        = 24'h000040;
   localparam int          L         = RD_LAT + 2;
   localparam int          N         = 8192;

   logic        vgaclk = 1'b0;
   logic        reset = 1'b1;
   logic        hsync_in = 1'b1, vsync_in = 1'b1, blank_in = 1'b0, sync_in = 1'b0;
   logic        enable_pixel_in = 1'b0;
   logic [18:0] DataAdr_in = '0;
   logic [18:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic        hsync_out, vsync_out, blank_out, sync_out, frame_active;
   logic [7:0]  red, green, blue;
`ifdef VGA_TEST_PATTERN_EN
   logic        test_mode = 1'b0;
`endif

   vga_pixel_fetch #(
      .RD_LAT    (RD_LAT),
      .MEM_DEPTH (MEM_DEPTH),
      .BG_COLOR  (BG)
   ) dut (
      .vgaclk          (vgaclk),
      .reset           (reset),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode       (test_mode),
`endif
      .hsync_in        (hsync_in),
      .vsync_in        (vsync_in),
      .blank_in        (blank_in),
      .sync_in         (sync_in),
      .DataAdr_in      (DataAdr_in),
      .enable_pixel_in (enable_pixel_in),
      .mem_addr        (mem_addr),
      .mem_rd          (mem_rd),
      .mem_rdata       (mem_rdata),
      .hsync_out       (hsync_out),
      .vsync_out       (vsync_out),
      .blank_out       (blank_out),
      .sync_out        (sync_out),
      .red             (red),
      .green           (green),
      .blue            (blue),
      .frame_active    (frame_active)
   );

   always #5 vgaclk = ~vgaclk;

   function automatic logic [7:0] mem_byte(input logic [18:0] a);
      return a[7:0] ^ a[15:8] ^ {a[18:16], 5'h15};
   endfunction

   // Frame memory: data appears RD_LAT cycles after the strobe, garbage otherwise
   logic [7:0] mem_pipe [RD_LAT];
   always @(posedge vgaclk) begin
      mem_pipe[0] <= mem_rd ? mem_byte(mem_addr) : 8'($urandom);
      for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
   end
   assign mem_rdata = mem_pipe[RD_LAT-1];

   // Per-cycle input history and model state
   bit          h_rst [N];
   bit          h_hs [N], h_vs [N], h_bl [N], h_sy [N], h_en [N], h_tm [N], h_act [N];
   logic [18:0] h_addr [N];
   int          h_col [N];
   int          n = 0;
   bit          m_active = 1'b0, m_prev_vs = 1'b1;
   int          m_col = 0;
   logic [18:0] m_addr = '0;
   int          compared = 0, mismatched = 0;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   function automatic bit rst_at(input int k);
      return (k < 0) ? 1'b1 : h_rst[k];
   endfunction

   function automatic bit rd_of(input int k);
      return h_en[k] && h_bl[k] && (int'(h_addr[k]) < MEM_DEPTH) && !h_tm[k];
   endfunction

   function automatic logic [23:0] pixel_colour(input int k);
      int idx;
      if (!h_act[k] || !h_bl[k]) return 24'h0;
      if (h_tm[k]) begin
         idx = h_col[k] / (H_ACTIVE / 8);
         if (idx > 7) idx = 7;
         return bars[idx];
      end
      if (h_en[k] && int'(h_addr[k]) < MEM_DEPTH) return {3{mem_byte(h_addr[k])}};
      return BG;
   endfunction

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, n);
      end
   endtask

   task automatic check_outputs();
      bit          flushed = 1'b0;
      bit          ehs = 1'b1, evs = 1'b1, ebl = 1'b0, esy = 1'b0;
      logic [23:0] ergb = 24'h0;
      for (int k = n - L; k < n; k++) if (rst_at(k)) flushed = 1'b1;
      if (!flushed) begin
         ehs  = h_hs[n-L];
         evs  = h_vs[n-L];
         ebl  = h_bl[n-L];
         esy  = h_sy[n-L];
         ergb = pixel_colour(n - L);
      end
      chk("rgb",          {red, green, blue}, ergb);
      chk("hsync_out",    24'(hsync_out), 24'(ehs));
      chk("vsync_out",    24'(vsync_out), 24'(evs));
      chk("blank_out",    24'(blank_out), 24'(ebl));
      chk("sync_out",     24'(sync_out),  24'(esy));
      chk("mem_rd",       24'(mem_rd), 24'(rst_at(n - 1) ? 1'b0 : rd_of(n - 1)));
      chk("mem_addr",     24'(mem_addr), 24'(m_addr));
      chk("frame_active", 24'(frame_active), 24'(m_active));
   endtask

   task automatic cyc(input bit rst, input bit hs, input bit vs, input bit bl, input bit sy,
                      input bit en, input logic [18:0] addr, input bit tm);
      @(negedge vgaclk);
      check_outputs();
      reset = rst; hsync_in = hs; vsync_in = vs; blank_in = bl; sync_in = sy;
      enable_pixel_in = en; DataAdr_in = addr;
`ifdef VGA_TEST_PATTERN_EN
      test_mode = tm;
`endif
      h_rst[n] = rst; h_hs[n] = hs; h_vs[n] = vs; h_bl[n] = bl; h_sy[n] = sy;
      h_en[n] = en; h_addr[n] = addr; h_tm[n] = tm;
      h_act[n] = m_active; h_col[n] = m_col;
      if (rst) begin
         m_active = 1'b0; m_prev_vs = 1'b1; m_col = 0; m_addr = '0;
      end else begin
         if (!vs && m_prev_vs) m_active = 1'b1;
         m_prev_vs = vs;
         m_col = bl ? (m_col + 1) % 2048 : 0;
         if (rd_of(n)) m_addr = addr;
      end
      n++;
   endtask

   function automatic logic [18:0] pick_addr();
      case ($urandom_range(0, 3))
         0:       return 19'(MEM_DEPTH - 1);
         1:       return 19'(MEM_DEPTH);
         default: return 19'($urandom_range(0, 524287));
      endcase
   endfunction

   task automatic rnd(input bit allow_fall);
      cyc(1'b0, $urandom_range(0, 9) != 0, allow_fall ? ($urandom_range(0, 15) != 0) : 1'b1,
          $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) != 0, pick_addr(), 1'b0);
   endtask

   initial begin
      repeat (4) cyc(1'b1, 1, 1, 0, 0, 0, 19'd0, 0);
      // Timing with no vsync edge: picture stays black
      repeat (40) cyc(1'b0, 1'($urandom), 1, 1, 1'($urandom), 1, pick_addr(), 0);
      // First vsync fall, then a visible pixel
      cyc(1'b0, 1, 0, 0, 0, 0, 19'd0, 0);
      cyc(1'b0, 1, 1, 1, 0, 1, 19'd100, 0);
      cyc(1'b0, 1, 1, 1, 0, 1, 19'(MEM_DEPTH - 1), 0);
      cyc(1'b0, 1, 1, 1, 0, 1, 19'(MEM_DEPTH), 0);
      cyc(1'b0, 1, 1, 1, 0, 0, 19'd200, 0);
      cyc(1'b0, 1, 1, 0, 0, 1, 19'd300, 0);
      repeat (600) rnd(1'b1);
      // Reset mid-line during back-to-back reads
      repeat (6) cyc(1'b0, 1, 1, 1, 0, 1, 19'($urandom_range(0, MEM_DEPTH - 1)), 0);
      cyc(1'b1, 1'($urandom), 1, 1, 1'($urandom), 1, pick_addr(), 0);
      repeat (30) rnd(1'b0);
      cyc(1'b0, 1, 0, 0, 0, 0, 19'd0, 0);
      repeat (400) rnd(1'b1);
`ifdef VGA_TEST_PATTERN_EN
      repeat (3) cyc(1'b0, 1, 1, 0, 0, 0, 19'd0, 1);
      for (int c = 0; c < H_ACTIVE; c++)
         cyc(1'b0, 1, 1, 1, 0, 1'($urandom), pick_addr(), 1);
      repeat (3) cyc(1'b0, 1, 1, 0, 0, 0, 19'd0, 1);
      repeat (100) rnd(1'b1);
`endif
      repeat (L + 2) cyc(1'b0, 1, 1, 0, 0, 0, 19'd0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Downstream neighbour of the VGA timing/address stage; consumes its timing signals, DataAdr_out and enable_pixel.
- Issues reads to the 8-bit grayscale frame memory and expands the returned byte to 24-bit RGB.
- Delays all sync/blank signals so they line up with the pixel data at the DAC pins.
- Sits between the VGA timing/address stage and the board video DAC.

Parameters:
- RD_LAT, 2, frame-memory read latency in cycles from mem_addr/mem_rd registered to mem_rdata valid (1..4).
- MEM_DEPTH, 307200, number of valid byte addresses; addresses ≥ MEM_DEPTH are out of range.
- BG_COLOR, 24'h000040, RGB shown in the visible region when enable_pixel is low.
- H_ACTIVE, 640, visible pixels per line (test pattern only).

Ports:
- vgaclk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- hsync_in  in  1  active-low hsync from the timing stage
- vsync_in  in  1  active-low vsync from the timing stage
- blank_in  in  1  1 = visible region (DAC blank_n convention)
- sync_in  in  1  composite sync to DAC, passed through
- DataAdr_in  in  19  pixel byte address
- enable_pixel_in  in  1  1 = current pixel lies inside the image
- mem_addr  out  19  frame-memory read address
- mem_rd  out  1  read strobe
- mem_rdata  in  8  grayscale byte, valid RD_LAT cycles after the strobe
- hsync_out, vsync_out, blank_out, sync_out  out  1 each  aligned timing signals
- red, green, blue  out  8 each  pixel colour
- frame_active  out  1  high once the first full frame has started

Behaviour:
- Pipeline latency L = RD_LAT + 2 from input to output.
  - Cycle 0: register mem_addr/mem_rd.
  - After RD_LAT cycles, mem_rdata is valid.
  - Final cycle: register RGB.
- hsync/vsync/blank/sync and the qualifiers (enable, in-range, visible) pass through a depth-L delay line, so outputs match their inputs exactly L cycles later.
- mem_rd = enable_pixel_in & blank_in & (DataAdr_in < MEM_DEPTH).
  - mem_addr is loaded only when mem_rd is 1; otherwise it holds its value.
- Output colour selection, using signals delayed by L cycles:
  - blank = 0 → RGB = 0.
  - else enable = 0 or out of range → BG_COLOR.
  - else red = green = blue = mem_rdata.
- FSM (state enum):
  - S_WAIT: entered on reset. Forces RGB = 0 regardless of the path above.
  - S_WAIT → S_ACTIVE on the first falling edge of vsync_in, detected against a registered copy.
  - S_ACTIVE: held until reset.
  - frame_active = 1 in S_ACTIVE. The RGB gate uses the state flag delayed by L, so no partial frame is shown.
- Reset values:
  - hsync_out = vsync_out = 1; sync_out = 0; blank_out = 0.
  - RGB = 0; mem_addr = 0; mem_rd = 0; frame_active = 0.
  - All delay-line stages take the same inactive values.
- Reset mid-frame: outputs take reset values on the next edge. The pipeline drains to inactive values and the FSM returns to S_WAIT.
- Address exactly MEM_DEPTH−1: read issued. Address MEM_DEPTH: no read, BG_COLOR shown.
- Back-to-back enables give one read per cycle. There are no stalls; the memory must accept a read every cycle.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - Adds input test_mode (1 bit).
  - An 11-bit column counter increments while blank_in = 1 and clears while blank_in = 0.
  - With test_mode = 1, colour comes from 8 vertical bars of width H_ACTIVE/8, in order: white, yellow, cyan, green, magenta, red, blue, black.
  - The bar index is delayed L cycles along with the other signals. mem_rd is forced to 0. blank and FSM gating still apply.
- When undefined: no port, no counter; behaviour is exactly as above.

Decomposition:
- Package vga_pix_pkg holds:
  - fetch_state_t enum (S_WAIT, S_ACTIVE).
  - RGB_BLACK and the 8-entry bar colour table.
  - Function latency(rd_lat) = rd_lat + 2.
- Sub-module vga_sync_delay: a parameterised shift register (WIDTH, DEPTH, RESET_VAL) with synchronous active-high reset, used for the timing/qualifier delay line.

Test Plan:
- Reset, then timing with no vsync edge, enable = 1, mem_rdata = 8'h80 → RGB stays 0, frame_active = 0; hsync_out follows hsync_in after L = 4 cycles.
- vsync_in falls, then a visible pixel at addr 100, mem_rdata = 8'h5A → mem_addr = 100 with mem_rd = 1 after 1 cycle; RGB = 5A5A5A exactly 4 cycles after the input.
- blank_in = 1, enable_pixel_in = 0 → RGB = 000040 and mem_rd = 0; blank_in = 0 → RGB = 000000.
- DataAdr_in = 307199, then 307200 with enable = 1 → first gives a read and gray output; second gives mem_rd = 0 and BG_COLOR.
- Reset asserted mid-line during active reads → next cycle all outputs are at reset values; after release, RGB = 0 until the next vsync falling edge.
- (VGA_TEST_PATTERN_EN) test_mode = 1, full 640-pixel line → columns 0–79 FFFFFF, 80–159 FFFF00, …, 560–639 000000, each 4 cycles late; mem_rd = 0 throughout.
